// File: rtl/wb_line_buffer.sv
// Write-back line buffer between the cache line port and main_mem: evictions are queued and drained in order.
// Build option WB_FWD_EN: refills are served from the youngest matching queued line and misses bypass the queue.
module wb_line_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int DEPTH         = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_LEN-1:0]                    c_addr,
    input  logic                                   c_rd_req,
    output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    c_rd_line,
    input  logic                                   c_wr_req,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    c_wr_line,
    output logic                                   c_gnt,
    output logic [ADDR_LEN-1:0]                    m_addr,
    output logic                                   m_rd_req,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    m_rd_line,
    output logic                                   m_wr_req,
    output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]    m_wr_line,
    input  logic                                   m_gnt
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;

    typedef logic [LINE_SIZE-1:0][31:0] line_t;
    typedef enum logic [2:0] {IDLE, GNT, MEM_RD, RD_DONE, MEM_WR} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                c_gnt_q, c_gnt_d;
    logic                m_rd_req_q, m_rd_req_d;
    logic                m_wr_req_q, m_wr_req_d;
    logic [ADDR_LEN-1:0] m_addr_q, m_addr_d;
    line_t               m_wr_line_q, m_wr_line_d;
    line_t               c_rd_line_q, c_rd_line_d;
    logic [ADDR_LEN-1:0] buf_addr_q [DEPTH];
    line_t               buf_line_q [DEPTH];

    logic push;
    logic drain;
    logic start_rd;
    logic full;
    logic empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef WB_FWD_EN
    logic          hit;
    line_t         hit_line;
    logic [PW-1:0] idx;

    // Walk from the newest entry backwards so the latest copy of a line wins.
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = wr_ptr_q - PW'(i + 1);
            if (!hit && (CW'(i) < count_q) && (buf_addr_q[idx] == c_addr)) begin
                hit      = 1'b1;
                hit_line = buf_line_q[idx];
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        c_gnt_d     = 1'b0;
        m_rd_req_d  = m_rd_req_q;
        m_wr_req_d  = m_wr_req_q;
        m_addr_d    = m_addr_q;
        m_wr_line_d = m_wr_line_q;
        c_rd_line_d = c_rd_line_q;
        push        = 1'b0;
        drain       = 1'b0;
        start_rd    = 1'b0;

        case (state_q)
            IDLE: begin
                if (c_wr_req && !full) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                    c_gnt_d  = 1'b1;
                    state_d  = GNT;
                end else if (c_wr_req) begin
                    drain = 1'b1;
                end else if (c_rd_req) begin
`ifdef WB_FWD_EN
                    if (hit) begin
                        c_rd_line_d = hit_line;
                        c_gnt_d     = 1'b1;
                        state_d     = GNT;
                    end else begin
                        start_rd = 1'b1;
                    end
`else
                    // Memory is only read once every queued write has landed.
                    if (!empty) drain = 1'b1;
                    else        start_rd = 1'b1;
`endif
                end else if (!empty) begin
                    drain = 1'b1;
                end
            end
            GNT: begin
                state_d = IDLE;
            end
            MEM_WR: begin
                if (m_gnt) begin
                    m_wr_req_d = 1'b0;
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                    count_d    = count_q - CW'(1);
                    state_d    = IDLE;
                end
            end
            MEM_RD: begin
                if (m_gnt) begin
                    m_rd_req_d  = 1'b0;
                    c_rd_line_d = m_rd_line;
                    c_gnt_d     = 1'b1;
                    state_d     = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (drain) begin
            m_wr_req_d  = 1'b1;
            m_addr_d    = buf_addr_q[rd_ptr_q];
            m_wr_line_d = buf_line_q[rd_ptr_q];
            state_d     = MEM_WR;
        end
        if (start_rd) begin
            m_rd_req_d = 1'b1;
            m_addr_d   = c_addr;
            state_d    = MEM_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            c_gnt_q     <= 1'b0;
            m_rd_req_q  <= 1'b0;
            m_wr_req_q  <= 1'b0;
            m_addr_q    <= '0;
            m_wr_line_q <= '0;
            c_rd_line_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            c_gnt_q     <= c_gnt_d;
            m_rd_req_q  <= m_rd_req_d;
            m_wr_req_q  <= m_wr_req_d;
            m_addr_q    <= m_addr_d;
            m_wr_line_q <= m_wr_line_d;
            c_rd_line_q <= c_rd_line_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr_q[i] <= '0;
                buf_line_q[i] <= '0;
            end
        end else if (push) begin
            buf_addr_q[wr_ptr_q] <= c_addr;
            buf_line_q[wr_ptr_q] <= c_wr_line;
        end
    end

    assign c_gnt     = c_gnt_q;
    assign c_rd_line = c_rd_line_q;
    assign m_addr    = m_addr_q;
    assign m_rd_req  = m_rd_req_q;
    assign m_wr_req  = m_wr_req_q;
    assign m_wr_line = m_wr_line_q;

endmodule

// File: tb/tb_wb_line_buffer.sv
// Directed bench for wb_line_buffer; memory grants are driven by hand, expectations computed by hand.
module tb_wb_line_buffer;
    typedef logic [7:0][31:0] line_t;

    logic       clk;
    logic       rst;
    logic [8:0] c_addr;
    logic       c_rd_req;
    line_t      c_rd_line;
    logic       c_wr_req;
    line_t      c_wr_line;
    logic       c_gnt;
    logic [8:0] m_addr;
    logic       m_rd_req;
    line_t      m_rd_line;
    logic       m_wr_req;
    line_t      m_wr_line;
    logic       m_gnt;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cycles = 0;

    wb_line_buffer #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_rd_req(c_rd_req), .c_rd_line(c_rd_line),
        .c_wr_req(c_wr_req), .c_wr_line(c_wr_line), .c_gnt(c_gnt),
        .m_addr(m_addr), .m_rd_req(m_rd_req), .m_rd_line(m_rd_line),
        .m_wr_req(m_wr_req), .m_wr_line(m_wr_line), .m_gnt(m_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (m_rd_req) rd_cycles <= rd_cycles + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t mk_line(input logic [31:0] b);
        line_t l;
        for (int i = 0; i < 8; i++) l[i] = b + 32'(i);
        return l;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        c_addr = '0; c_rd_req = 1'b0; c_wr_req = 1'b0; c_wr_line = '0;
        m_gnt = 1'b0; m_rd_line = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; holds the request and returns the number of negedges until c_gnt (0 = none).
    task automatic cache_req(input logic wr, input logic [8:0] a, input line_t l,
                             input int budget, output int lat);
        c_wr_req = wr; c_rd_req = !wr; c_addr = a; c_wr_line = l;
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (c_gnt) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic idle_req();
        c_wr_req = 1'b0; c_rd_req = 1'b0;
    endtask

    task automatic wait_mwr(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_wr_req) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, hits, rd0, nev, gnt_cyc, got_cyc;
        logic       ev_rd   [4];
        logic [8:0] ev_addr [4];
        line_t      lz;

        do_reset();
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_m_rd_req", m_rd_req, 0);
        chk("rst_m_wr_req", m_wr_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_c_rd_line", c_rd_line, 0);
        chk("rst_m_wr_line", m_wr_line, 0);
        chk("rst_count", dut.count_q, 0);

        // Reset in the middle of a memory write
        cache_req(1'b1, 9'h012, mk_line(0), 5, lat);
        chk("t1_wr_lat", lat, 1);
        idle_req();
        wait_mwr(10);
        chk("t1_mwr_up", m_wr_req, 1);
        rst = 1'b1;
        #1;
        chk("t1_async_mwr", m_wr_req, 0);
        chk("t1_async_maddr", m_addr, 0);
        chk("t1_async_mline", m_wr_line, 0);
        @(negedge clk);
        chk("t1_count", dut.count_q, 0);
        chk("t1_c_gnt", c_gnt, 0);
        rst = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_wr_req) hits++;
        end
        chk("t1_no_mwr_after_rst", hits, 0);

        // Single write then stalled drain
        do_reset();
        cache_req(1'b1, 9'h012, mk_line(0), 5, lat);
        chk("t2_wr_lat", lat, 1);
        chk("t2_count", dut.count_q, 1);
        idle_req();
        @(negedge clk);
        chk("t2_gnt_pulse", c_gnt, 0);
        repeat (8) @(negedge clk);
        chk("t2_mwr_held", m_wr_req, 1);
        chk("t2_maddr", m_addr, 9'h012);
        chk("t2_mline", m_wr_line, mk_line(0));
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        chk("t2_mwr_drop", m_wr_req, 0);
        chk("t2_count_pop", dut.count_q, 0);

        // Full buffer stalls the fifth eviction until one drain completes
        do_reset();
        cache_req(1'b1, 9'h100, mk_line(32'h100), 5, lat);
        chk("t3_lat0", lat, 1);
        for (int k = 1; k < 4; k++) begin
            cache_req(1'b1, 9'h100 + 9'(k), mk_line(32'h100 + 32'(16 * k)), 5, lat);
            chk("t3_lat_b2b", lat, 2);
        end
        chk("t3_full", dut.count_q, 4);
        cache_req(1'b1, 9'h0FF, mk_line(32'hF0), 20, lat);
        chk("t3_no_gnt_full", lat, 0);
        chk("t3_mwr", m_wr_req, 1);
        chk("t3_maddr_head", m_addr, 9'h100);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        cache_req(1'b1, 9'h0FF, mk_line(32'hF0), 10, lat);
        chk("t3_gnt_after_pop", lat, 1);
        chk("t3_count4", dut.count_q, 4);
        idle_req();
        @(negedge clk);
        wait_mwr(10);
        chk("t3_next_head", m_addr, 9'h101);

`ifdef WB_FWD_EN
        // Forwarding: youngest copy wins, miss bypasses queued writes
        do_reset();
        rd0 = rd_cycles;
        cache_req(1'b1, 9'h012, mk_line(32'h1000), 5, lat);
        chk("t4_wx", lat, 1);
        cache_req(1'b1, 9'h012, mk_line(32'h2000), 5, lat);
        chk("t4_wy", lat, 2);
        cache_req(1'b0, 9'h012, '0, 5, lat);
        chk("t4_rd_lat", lat, 2);
        chk("t4_rd_line", c_rd_line, mk_line(32'h2000));
        chk("t4_no_mrd", rd_cycles - rd0, 0);
        chk("t4_count", dut.count_q, 2);
        c_addr = 9'h040;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_rd_req) break;
        end
        chk("t4_miss_mrd", m_rd_req, 1);
        chk("t4_miss_addr", m_addr, 9'h040);
        chk("t4_bypass_count", dut.count_q, 2);
        m_gnt = 1'b1; m_rd_line = mk_line(32'h3000);
        @(negedge clk);
        m_gnt = 1'b0;
        chk("t4_miss_gnt", c_gnt, 1);
        chk("t4_miss_line", c_rd_line, mk_line(32'h3000));
        idle_req();
`endif

        // Read behind two queued writes
        do_reset();
        cache_req(1'b1, 9'h021, mk_line(32'h21000), 5, lat);
        chk("t5_w1", lat, 1);
        cache_req(1'b1, 9'h022, mk_line(32'h22000), 5, lat);
        chk("t5_w2", lat, 2);
        c_wr_req = 1'b0; c_rd_req = 1'b1; c_addr = 9'h030;
        nev = 0; gnt_cyc = -10; got_cyc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (c_gnt) begin
                got_cyc = cyc;
                break;
            end
            if (m_gnt) m_gnt = 1'b0;
            else if (m_wr_req || m_rd_req) begin
                if (nev < 4) begin
                    ev_rd[nev]   = m_rd_req;
                    ev_addr[nev] = m_addr;
                end
                nev++;
                m_gnt = 1'b1;
                m_rd_line = mk_line(32'h30000);
                gnt_cyc = cyc;
            end
        end
        m_gnt = 1'b0;
        idle_req();
        chk("t5_gnt_latency", got_cyc - gnt_cyc, 1);
        chk("t5_rd_line", c_rd_line, mk_line(32'h30000));
`ifdef WB_FWD_EN
        chk("t5_nev", nev, 1);
        chk("t5_ev0_rd", ev_rd[0], 1);
        chk("t5_ev0_addr", ev_addr[0], 9'h030);
        chk("t5_count", dut.count_q, 2);
`else
        chk("t5_nev", nev, 3);
        chk("t5_ev0", {ev_rd[0], ev_addr[0]}, {1'b0, 9'h021});
        chk("t5_ev1", {ev_rd[1], ev_addr[1]}, {1'b0, 9'h022});
        chk("t5_ev2", {ev_rd[2], ev_addr[2]}, {1'b1, 9'h030});
        chk("t5_count", dut.count_q, 0);
`endif

        // Slow memory read
        do_reset();
        lz = mk_line(32'hA5A50000);
        cache_req(1'b0, 9'h1A5, '0, 50, lat);
        chk("t6_no_gnt", lat, 0);
        chk("t6_mrd", m_rd_req, 1);
        chk("t6_maddr", m_addr, 9'h1A5);
        m_gnt = 1'b1; m_rd_line = lz;
        @(negedge clk);
        m_gnt = 1'b0; m_rd_line = ~lz;
        chk("t6_gnt", c_gnt, 1);
        chk("t6_line", c_rd_line, lz);
        chk("t6_mrd_drop", m_rd_req, 0);
        idle_req();
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (c_gnt) hits++;
        end
        chk("t6_gnt_once", hits, 0);
        chk("t6_line_hold", c_rd_line, lz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
